// File: rtl/ahb_lite_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single slave port. An address phase that
// loses arbitration is parked in a per-master hold register and replayed when it wins.
module ahb_lite_arbiter #(
    parameter bit RR_ARB = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_haddr,
    input  logic [1:0]  m0_htrans,
    input  logic        m0_hwrite,
    input  logic        m0_hmastlock,
    input  logic [2:0]  m0_hsize,
    input  logic [2:0]  m0_hburst,
    input  logic [31:0] m0_hwdata,
    output logic [31:0] m0_hrdata,
    output logic        m0_hready,
    output logic        m0_hresp,
    input  logic [31:0] m1_haddr,
    input  logic [1:0]  m1_htrans,
    input  logic        m1_hwrite,
    input  logic        m1_hmastlock,
    input  logic [2:0]  m1_hsize,
    input  logic [2:0]  m1_hburst,
    input  logic [31:0] m1_hwdata,
    output logic [31:0] m1_hrdata,
    output logic        m1_hready,
    output logic        m1_hresp,
    output logic [31:0] s_haddr,
    output logic [31:0] s_hwdata,
    output logic [1:0]  s_htrans,
    output logic [2:0]  s_hsize,
    output logic [2:0]  s_hburst,
    output logic        s_hwrite,
    output logic        s_hmastlock,
    input  logic [31:0] s_hrdata,
    input  logic        s_hreadyout,
    input  logic        s_hresp,
    output logic        grant
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    typedef struct packed {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
        logic        hmastlock;
    } aphase_t;

    aphase_t     live   [2];
    logic [31:0] hwdata [2];
    aphase_t     hold_q [2];
    logic [1:0]  hold_full_q, hold_full_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        dval_q, dval_d;
    logic        downer_q, downer_d;
    logic [1:0]  req, hready, hresp, capture;
    logic        locked, grant_c;
    aphase_t     sel;

    assign live[0]   = {m0_haddr, m0_htrans, m0_hwrite, m0_hsize, m0_hburst, m0_hmastlock};
    assign live[1]   = {m1_haddr, m1_htrans, m1_hwrite, m1_hsize, m1_hburst, m1_hmastlock};
    assign hwdata[0] = m0_hwdata;
    assign hwdata[1] = m1_hwdata;

    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign req[gi] = hold_full_q[gi] | (live[gi].htrans == HT_NONSEQ);
        // A pending data phase reports the slave's ready before anything else.
        assign hready[gi] = rst                                  ? 1'b1 :
                            (dval_q && (downer_q == 1'(gi)))     ? s_hreadyout :
                            hold_full_q[gi]                      ? 1'b0 :
                            (grant_c == 1'(gi))                  ? s_hreadyout : 1'b1;
        assign hresp[gi]   = !rst && dval_q && (downer_q == 1'(gi)) && s_hresp;
        assign capture[gi] = hready[gi] && (grant_c != 1'(gi)) && (live[gi].htrans == HT_NONSEQ);
    end

    always_comb begin
        locked  = (live[owner_q].htrans == HT_BUSY) || (live[owner_q].htrans == HT_SEQ) ||
                  live[owner_q].hmastlock;
        grant_c = owner_q;
        if (rst) begin
            grant_c = 1'b0;
        end else if (!s_hreadyout || locked) begin
            grant_c = owner_q;
        end else if (req[0] && req[1]) begin
            grant_c = RR_ARB ? ~last_q : 1'b0;
        end else if (req[0]) begin
            grant_c = 1'b0;
        end else if (req[1]) begin
            grant_c = 1'b1;
        end
    end

    always_comb begin
        sel = hold_full_q[grant_c] ? hold_q[grant_c] : live[grant_c];
        if (rst) begin
            sel.htrans = HT_IDLE;
        end
    end

    always_comb begin
        owner_d     = owner_q;
        last_d      = last_q;
        dval_d      = dval_q;
        downer_d    = downer_q;
        hold_full_d = hold_full_q | capture;
        if (s_hreadyout) begin
            owner_d  = grant_c;
            downer_d = grant_c;
            dval_d   = (sel.htrans == HT_NONSEQ) || (sel.htrans == HT_SEQ);
            if (hold_full_q[grant_c]) begin
                hold_full_d[grant_c] = 1'b0;
            end
            if (sel.htrans == HT_NONSEQ) begin
                last_d = grant_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            dval_q      <= 1'b0;
            downer_q    <= 1'b0;
            hold_full_q <= 2'b00;
        end else begin
            owner_q     <= owner_d;
            last_q      <= last_d;
            dval_q      <= dval_d;
            downer_q    <= downer_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Hold payload needs no reset: it is only read while its full flag is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (capture[i]) begin
                hold_q[i] <= live[i];
            end
        end
    end

    assign s_haddr     = sel.haddr;
    assign s_htrans    = sel.htrans;
    assign s_hwrite    = sel.hwrite;
    assign s_hsize     = sel.hsize;
    assign s_hburst    = sel.hburst;
    assign s_hmastlock = sel.hmastlock;
    assign s_hwdata    = hwdata[downer_q];
    assign grant       = grant_c;

    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;
    assign m0_hready = hready[0];
    assign m1_hready = hready[1];
    assign m0_hresp  = hresp[0];
    assign m1_hresp  = hresp[1];

endmodule
